// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared types and constants for the button/switch input conditioner.
package input_cond_pkg;
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
   localparam int NUM_BTN = 4;
   localparam int NUM_SW = 2;
   localparam int MS_PER_S = 1000;
   function automatic int ms_cycles(input int clk_hz);
      return clk_hz / MS_PER_S;
   endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: 2-FF synchronizer plus tick-based debounce counter for one raw input.
// flip is high in the cycle whose edge toggles stable, so callers can act on that same edge.
module debounce_ch #(
   parameter int DEBOUNCE_MS = 20,
   parameter bit INV = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic tick,
   output logic stable,
   output logic flip
);
   localparam int CW = $clog2(DEBOUNCE_MS + 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic val;
   assign val = sync[1] ^ INV;
   assign flip = (val != stable) && tick && (cnt == CW'(DEBOUNCE_MS - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {2{INV}};
         stable <= 1'b0;
         cnt <= '0;
      end else begin
         sync <= {sync[0], raw};
         stable <= stable ^ flip;
         cnt <= (val == stable || flip) ? '0 : cnt + CW'(tick);
      end
   end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces 4 active-low keys and 2 switches, and generates
// press pulses with per-button auto-repeat on a shared 1 ms tick.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int DEBOUNCE_MS = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS = 100,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = 4'b0011
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [NUM_BTN-1:0] key_n,
   input  logic [NUM_SW-1:0]  sw_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic [NUM_SW-1:0]  sw_level
);
   localparam int TICK_CYC = ms_cycles(CLK_HZ);
   localparam int PW = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;
   localparam int RMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int RW = $clog2(RMAX + 1);
   logic [PW-1:0] pcnt;
   logic tick;
   logic [NUM_BTN-1:0] flip_b;
   logic [NUM_SW-1:0] sw_flip_unused;
   assign tick = pcnt == PW'(TICK_CYC - 1);
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) pcnt <= '0;
      else pcnt <= tick ? '0 : pcnt + 1'b1;
   end
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_key
      debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS), .INV(1'b1)) u_ch (
         .clk(clk_clk), .rst_n(reset_reset_n), .raw(key_n[i]), .tick(tick),
         .stable(btn_level[i]), .flip(flip_b[i]));
   end
   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS), .INV(1'b0)) u_ch (
         .clk(clk_clk), .rst_n(reset_reset_n), .raw(sw_raw[i]), .tick(tick),
         .stable(sw_level[i]), .flip(sw_flip_unused[i]));
   end
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      rep_state_t st, st_nx;
      logic [RW-1:0] cnt, cnt_nx;
      logic pls, pls_nx, rise, fall, dly_end, rpt_end;
      assign rise = flip_b[i] & ~btn_level[i];
      assign fall = flip_b[i] & btn_level[i];
      assign dly_end = tick && cnt == RW'(REPEAT_DELAY_MS - 1);
      assign rpt_end = tick && cnt == RW'(REPEAT_RATE_MS - 1);
      assign btn_pulse[i] = pls;
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            st <= IDLE;
            cnt <= '0;
            pls <= 1'b0;
         end else begin
            st <= st_nx;
            cnt <= cnt_nx;
            pls <= pls_nx;
         end
      end
      always_comb begin
         st_nx = st;
         cnt_nx = cnt;
         if (fall) begin
            st_nx = IDLE;
            cnt_nx = '0;
         end else if (st == IDLE) begin
            st_nx = rise ? DELAY : IDLE;
            cnt_nx = '0;
         end else if (st == DELAY) begin
            st_nx = (dly_end && REPEAT_MASK[i]) ? REPEAT : DELAY;
            cnt_nx = dly_end ? '0 : cnt + RW'(tick);
         end else begin
            cnt_nx = rpt_end ? '0 : cnt + RW'(tick);
         end
      end
      // Buttons without repeat keep cycling the delay count silently, so it never wraps.
      always_comb begin
         pls_nx = ~fall & ((st == IDLE && rise) || (st == DELAY && dly_end && REPEAT_MASK[i])
                           || (st == REPEAT && rpt_end));
      end
   end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; expected pulse vectors and spacings are queued
// with each stimulus and consumed by a monitor whenever btn_pulse fires.
module tb_input_conditioner;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic [1:0] sw_raw = 2'b00;
   logic [3:0] btn_level, btn_pulse;
   logic [1:0] sw_level;
   int cyc = 0, last_cyc = 0, seen = 0, n_chk = 0, n_err = 0, pc = 0, b = 0;
   logic [3:0] prev_pulse = 4'h0;
   typedef struct {logic [3:0] vec; int gap;} exp_t;
   exp_t sb[$];
   exp_t e;

   input_conditioner #(
      .CLK_HZ(10000), .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2),
      .REPEAT_MASK(4'b0011)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n), .sw_raw(sw_raw),
      .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_level(sw_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input logic [3:0] vec, input int gap);
      sb.push_back('{vec, gap});
   endtask

   task automatic wait_seen(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && seen < n; k++) @(negedge clk);
      chk(tag, seen, n);
   endtask

   // gap 0 marks the first pulse of a press, whose timing is checked by the stimulus
   always @(negedge clk) begin
      if (btn_pulse != 4'h0) begin
         chk("no_double", {28'b0, btn_pulse & prev_pulse}, 0);
         if (sb.size() == 0) chk("unexpected", {28'b0, btn_pulse}, 0);
         else begin
            e = sb.pop_front();
            chk("pulse_vec", {28'b0, btn_pulse}, {28'b0, e.vec});
            if (e.gap != 0) chk("pulse_gap", cyc - last_cyc, e.gap);
         end
         last_cyc = cyc;
         seen++;
      end
      prev_pulse = btn_pulse;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_level", btn_level, 0);
      chk("rst_pulse", btn_pulse, 0);
      chk("rst_sw", sw_level, 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("idle_level", btn_level, 0);
      chk("idle_sw", sw_level, 0);
      // key0 repeats, key3 is masked: one joint press pulse, then key0 alone
      push(4'b1001, 0); push(4'b0001, 50); push(4'b0001, 20); push(4'b0001, 20); push(4'b0001, 20);
      key_n = 4'b0110;
      pc = cyc;
      wait_seen("press", 1, 40);
      chk("press_lat", (last_cyc - pc) <= 34, 1);
      chk("press_lvl", btn_level, 4'b1001);
      wait_seen("repeat", 4, 200);
      chk("hold_lvl", btn_level, 4'b1001);
      key_n = 4'hF;
      wait_seen("last_rep", 5, 40);
      repeat (40) @(negedge clk);
      chk("release_lvl", btn_level, 0);
      for (int k = 0; k < 6; k++) begin
         key_n[1] = ~key_n[1];
         repeat (15) @(negedge clk);
         chk("bounce_lvl", btn_level[1], 0);
      end
      repeat (40) @(negedge clk);
      chk("bounce_end", btn_level, 0);
      sw_raw = 2'b10;
      repeat (40) @(negedge clk);
      chk("sw_on", sw_level, 2'b10);
      sw_raw = 2'b00;
      repeat (5) @(negedge clk);
      sw_raw = 2'b10;
      chk("sw_glitch_mid", sw_level, 2'b10);
      repeat (40) @(negedge clk);
      chk("sw_glitch", sw_level, 2'b10);
      b = seen;
      push(4'hF, 0); push(4'b0011, 50); push(4'b0011, 20);
      key_n = 4'h0;
      wait_seen("all_press", b + 1, 40);
      chk("all_lvl", btn_level, 4'hF);
      wait_seen("all_rep", b + 3, 120);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_lvl", btn_level, 0);
      chk("arst_pulse", btn_pulse, 0);
      chk("arst_sw", sw_level, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pc = cyc;
      push(4'hF, 0);
      wait_seen("fresh", b + 4, 45);
      chk("fresh_lat", (last_cyc - pc) >= 20 && (last_cyc - pc) <= 34, 1);
      key_n = 4'hF;
      repeat (60) @(negedge clk);
      chk("final_lvl", btn_level, 0);
      chk("sw_back", sw_level, 2'b10);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
